counter_bank: RTL

- Multi-channel, parametrised event counter bank; next generation of the single 32-bit event counter.
- NCH independent counters of WIDTH bits, each with a per-channel event input.
- Selectable wrap or saturate on overflow, with a sticky overflow flag per channel.
- An atomic snapshot of all channels into shadow registers, optionally clearing the live counters; shadows are read back through an addressed read port with a one-cycle strobe/valid handshake.
- Feeds the status/telemetry path, e.g. a serial tx-data formatter that reads counts by channel index.

---
 rtl/counter_bank.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/counter_bank.sv
// counter_bank: multi-channel event counter bank with atomic snapshot and addressed read-back.
//
// NCH independent WIDTH-bit counters, one event input per channel. On overflow a counter
// either wraps to zero or holds at all-ones (SATURATE), and sets a sticky per-channel
// overflow flag. A snapshot copies every live counter and flag into shadow registers in
// the same cycle, optionally clearing the live state. Shadows are read through a registered
// read port: a strobe in one cycle gives a one-cycle valid pulse in the next.
//
// Optional feature, enabled by defining COUNTER_BANK_THRESH_EN:
//   adds i_thresh / o_thresh_hit, a sticky per-channel flag that sets when an event moves the
//   live count to exactly i_thresh.
//
// Ports:
//   i_clk          clock, all logic on posedge
//   i_reset_n      synchronous active-low reset
//   i_event        per-channel event strobes
//   i_snap         snapshot strobe
//   i_snap_clr     with i_snap: also clear live counters and live overflow flags
//   i_rd_stb       read request
//   i_rd_addr      channel index for the read, sampled with i_rd_stb
//   o_rd_valid     read response valid (one-cycle pulse)
//   o_rd_data      shadow count of the addressed channel
//   o_rd_ovf       shadow overflow flag of the addressed channel
//   o_rd_err       addressed channel does not exist
//   o_ovf_any      registered OR of all live overflow flags
//   i_thresh       (optional) threshold value
//   o_thresh_hit   (optional) sticky per-channel threshold hit flags

module counter_bank #(
    parameter int unsigned NCH      = 8,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned AW       = 3,
    parameter int unsigned SATURATE = 0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [NCH-1:0]   i_event,
    input  logic             i_snap,
    input  logic             i_snap_clr,
    input  logic             i_rd_stb,
    input  logic [AW-1:0]    i_rd_addr,
`ifdef COUNTER_BANK_THRESH_EN
    input  logic [WIDTH-1:0] i_thresh,
    output logic [NCH-1:0]   o_thresh_hit,
`endif
    output logic             o_rd_valid,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_rd_ovf,
    output logic             o_rd_err,
    output logic             o_ovf_any
);

    localparam logic [WIDTH-1:0] CntMax = '1;
    localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);

    // Live state
    logic [WIDTH-1:0] cnt_q [NCH];
    logic [WIDTH-1:0] cnt_d [NCH];
    logic [NCH-1:0]   ovf_q, ovf_d;

    // Shadow state
    logic [WIDTH-1:0] shadow_q [NCH];
    logic [WIDTH-1:0] shadow_d [NCH];
    logic [NCH-1:0]   shadow_ovf_q, shadow_ovf_d;

    // Read port
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_ovf_q, rd_ovf_d;
    logic             rd_err_q, rd_err_d;

    logic             ovf_any_q, ovf_any_d;
    logic             clr_live;

    assign clr_live = i_snap & i_snap_clr;

    // Live counters. A clear restarts a channel at 1 when it has an event in the same cycle,
    // so no event is lost across a snapshot-and-clear.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            cnt_d[k] = cnt_q[k];
            ovf_d[k] = ovf_q[k];
            if (clr_live) begin
                cnt_d[k] = i_event[k] ? CntOne : '0;
                ovf_d[k] = 1'b0;
            end else if (i_event[k]) begin
                if (cnt_q[k] == CntMax) begin
                    ovf_d[k] = 1'b1;
                    cnt_d[k] = (SATURATE != 0) ? CntMax : '0;
                end else begin
                    cnt_d[k] = cnt_q[k] + CntOne;
                end
            end
        end
    end

    // Shadows capture the registered live values, so this cycle's events are excluded.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            shadow_d[k] = shadow_q[k];
        end
        shadow_ovf_d = shadow_ovf_q;
        if (i_snap) begin
            for (int k = 0; k < NCH; k++) begin
                shadow_d[k] = cnt_q[k];
            end
            shadow_ovf_d = ovf_q;
        end
    end

    // Read mux works from shadow_q, so a read in a snapshot cycle returns the pre-snap value.
    always_comb begin
        rd_valid_d = i_rd_stb;
        rd_data_d  = rd_data_q;
        rd_ovf_d   = rd_ovf_q;
        rd_err_d   = rd_err_q;
        if (i_rd_stb) begin
            rd_err_d  = 1'b1;
            rd_data_d = '0;
            rd_ovf_d  = 1'b0;
            for (int k = 0; k < NCH; k++) begin
                if (i_rd_addr == AW'(k)) begin
                    rd_err_d  = 1'b0;
                    rd_data_d = shadow_q[k];
                    rd_ovf_d  = shadow_ovf_q[k];
                end
            end
        end
    end

    assign ovf_any_d = |ovf_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int k = 0; k < NCH; k++) begin
                cnt_q[k]    <= '0;
                shadow_q[k] <= '0;
            end
            ovf_q        <= '0;
            shadow_ovf_q <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_ovf_q     <= 1'b0;
            rd_err_q     <= 1'b0;
            ovf_any_q    <= 1'b0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                cnt_q[k]    <= cnt_d[k];
                shadow_q[k] <= shadow_d[k];
            end
            ovf_q        <= ovf_d;
            shadow_ovf_q <= shadow_ovf_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            rd_ovf_q     <= rd_ovf_d;
            rd_err_q     <= rd_err_d;
            ovf_any_q    <= ovf_any_d;
        end
    end

    assign o_rd_valid = rd_valid_q;
    assign o_rd_data  = rd_data_q;
    assign o_rd_ovf   = rd_ovf_q;
    assign o_rd_err   = rd_err_q;
    assign o_ovf_any  = ovf_any_q;

`ifdef COUNTER_BANK_THRESH_EN
    logic [NCH-1:0] hit_q, hit_d;

    // Compared against the next count, so the flag rises on the same edge as the counter.
    // A zero threshold never hits: the only way to reach zero is a wrap or a clear.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            hit_d[k] = hit_q[k];
            if (clr_live) begin
                hit_d[k] = i_event[k] && (i_thresh == CntOne);
            end else if (i_event[k] && (i_thresh != '0) && (cnt_d[k] == i_thresh)) begin
                hit_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            hit_q <= '0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign o_thresh_hit = hit_q;
`endif

endmodule
